data_ram_responder: RTL and testbench

- Word-organised data RAM. It is the responder end of the core's load/store RAM bus: the memory stage drives address, write data, write request and chip enable, and this block returns read data.
- Read data is combinational in the same cycle, because the memory stage merges byte and halfword stores into the returned word before writing back.
- Writes are posted through a one-entry write buffer with read forwarding.
- Also provides out-of-range error capture and access counters.

---
 rtl/data_ram_if.sv | 21 ++
 rtl/data_ram_responder.sv | 133 +++++++++++++
 tb/tb_data_ram_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_if.sv
// Load/store RAM bus between the memory stage (master) and the data RAM (slave).
interface data_ram_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] ram_addr_in;
   logic [DATA_WIDTH-1:0] ram_data_in;
   logic                  ram_write_request_in;
   logic                  ram_ce_in;
   logic [DATA_WIDTH-1:0] ram_data_out;

   modport master (
      output ram_addr_in, ram_data_in, ram_write_request_in, ram_ce_in,
      input  ram_data_out
   );

   modport slave (
      input  ram_addr_in, ram_data_in, ram_write_request_in, ram_ce_in,
      output ram_data_out
   );
endinterface

// File: rtl/data_ram_responder.sv
// Word-organised data RAM with a one-entry posted write buffer, combinational read with forwarding,
// sticky out-of-range error capture and access counters. Optional halt detect: DATA_RAM_HALT_DETECT_EN.
module data_ram_responder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [ADDR_WIDTH-1:0] HALT_ADDR  = ADDR_WIDTH'(32'h0000_FFFC)
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   data_ram_if.slave             bus,
   output logic                  err_out,
   output logic [ADDR_WIDTH-1:0] err_addr_out,
   output logic [31:0]           rd_cnt_out,
   output logic [31:0]           wr_cnt_out,
   output logic                  halt_out
);

   localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  wbuf_valid_d, wbuf_valid_q;
   logic [IDX_W-1:0]      wbuf_idx_d, wbuf_idx_q;
   logic [DATA_WIDTH-1:0] wbuf_data_d, wbuf_data_q;
   logic                  err_d, err_q;
   logic [ADDR_WIDTH-1:0] err_addr_d, err_addr_q;
   logic [31:0]           rd_cnt_d, rd_cnt_q;
   logic [31:0]           wr_cnt_d, wr_cnt_q;

   logic [ADDR_WIDTH:0]   addr_diff;
   logic [ADDR_WIDTH-1:0] widx_full;
   logic [IDX_W-1:0]      widx;
   logic                  in_range;
   logic                  acc_rd, acc_wr, acc_bad;
   logic [DATA_WIDTH-1:0] rdata;

   // The extra top bit of the difference is the borrow: set when the address is below BASE_ADDR.
   assign addr_diff = {1'b0, bus.ram_addr_in} - {1'b0, BASE_ADDR};
   assign widx_full = addr_diff[ADDR_WIDTH-1:0] >> 2;
   assign widx      = widx_full[IDX_W-1:0];
   assign in_range  = !addr_diff[ADDR_WIDTH] && (widx_full < DEPTH_W);

   assign acc_rd  = bus.ram_ce_in && !bus.ram_write_request_in && in_range;
   assign acc_wr  = bus.ram_ce_in &&  bus.ram_write_request_in && in_range;
   assign acc_bad = bus.ram_ce_in && !in_range;

   always_comb begin
      rdata = '0;
      if (!reset_in && bus.ram_ce_in && in_range) begin
         if (wbuf_valid_q && (wbuf_idx_q == widx))
            rdata = wbuf_data_q;
         else
            rdata = mem_q[widx];
      end
   end

   assign bus.ram_data_out = rdata;

   always_comb begin
      wbuf_valid_d = acc_wr;
      wbuf_idx_d   = wbuf_idx_q;
      wbuf_data_d  = wbuf_data_q;
      err_d        = err_q;
      err_addr_d   = err_addr_q;
      rd_cnt_d     = rd_cnt_q;
      wr_cnt_d     = wr_cnt_q;
      if (acc_wr) begin
         wbuf_idx_d  = widx;
         wbuf_data_d = bus.ram_data_in;
         wr_cnt_d    = wr_cnt_q + 32'd1;
      end
      if (acc_rd)
         rd_cnt_d = rd_cnt_q + 32'd1;
      // Only the first out-of-range address is kept.
      if (acc_bad && !err_q) begin
         err_d      = 1'b1;
         err_addr_d = bus.ram_addr_in;
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         wbuf_valid_q <= 1'b0;
         err_q        <= 1'b0;
         err_addr_q   <= '0;
         rd_cnt_q     <= '0;
         wr_cnt_q     <= '0;
      end else begin
         wbuf_valid_q <= wbuf_valid_d;
         err_q        <= err_d;
         err_addr_q   <= err_addr_d;
         rd_cnt_q     <= rd_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
      end
   end

   // Buffered entry drains into the array on the edge after acceptance; reset drops it via wbuf_valid_q.
   always_ff @(posedge clk_in) begin
      wbuf_idx_q  <= wbuf_idx_d;
      wbuf_data_q <= wbuf_data_d;
      if (wbuf_valid_q)
         mem_q[wbuf_idx_q] <= wbuf_data_q;
   end

   assign err_out      = err_q;
   assign err_addr_out = err_addr_q;
   assign rd_cnt_out   = rd_cnt_q;
   assign wr_cnt_out   = wr_cnt_q;

`ifdef DATA_RAM_HALT_DETECT_EN
   logic halt_d, halt_q;

   always_comb begin
      halt_d = halt_q;
      if (bus.ram_ce_in && bus.ram_write_request_in && (bus.ram_addr_in == HALT_ADDR))
         halt_d = 1'b1;
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) halt_q <= 1'b0;
      else          halt_q <= halt_d;
   end

   assign halt_out = halt_q;
`else
   // Constant 0; HALT_ADDR is folded in so the parameter stays referenced in this build.
   assign halt_out = &{1'b0, HALT_ADDR};
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: directed vector table, hand-written corner sequences and random
// traffic checked against a word-array reference model.
module tb_data_ram_responder;

   localparam int          M_DEPTH = 64;
   localparam logic [31:0] M_BASE  = 32'h0;
   localparam logic [31:0] M_HALT  = 32'h0000_FFFC;

   logic clk_in = 1'b0;
   logic reset_in = 1'b0;
   always #5 clk_in = ~clk_in;

   data_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_m ();
   data_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_s ();

   logic        m_err, s_err, m_halt, s_halt;
   logic [31:0] m_err_addr, s_err_addr, m_rd_cnt, s_rd_cnt, m_wr_cnt, s_wr_cnt;

   data_ram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(M_DEPTH),
                        .BASE_ADDR(M_BASE), .HALT_ADDR(M_HALT)) u_main (
      .clk_in(clk_in), .reset_in(reset_in), .bus(bus_m),
      .err_out(m_err), .err_addr_out(m_err_addr),
      .rd_cnt_out(m_rd_cnt), .wr_cnt_out(m_wr_cnt), .halt_out(m_halt));

   data_ram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
                        .BASE_ADDR(32'h0), .HALT_ADDR(32'h0000_FFFC)) u_small (
      .clk_in(clk_in), .reset_in(reset_in), .bus(bus_s),
      .err_out(s_err), .err_addr_out(s_err_addr),
      .rd_cnt_out(s_rd_cnt), .wr_cnt_out(s_wr_cnt), .halt_out(s_halt));

   int total = 0;
   int bad   = 0;

   // Reference model: a plain word array where a write takes effect at the accepting edge.
   logic [31:0] mem_m [M_DEPTH];
   bit          known_m [M_DEPTH];
   bit          pend_v = 0;
   int          pend_i = 0;
   logic [31:0] pend_old = '0;
   bit          pend_known = 0;
   logic [31:0] mo_rd = '0, mo_wr = '0, mo_erra = '0;
   bit          mo_err = 0, mo_halt = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      logic        c;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_inr(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(M_BASE);
      return (off >= 0) && (off / 4 < M_DEPTH);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((longint'(a) - longint'(M_BASE)) / 4);
   endfunction

   function automatic void m_update(input logic [31:0] a, input logic [31:0] d, input logic w, input logic c);
      bit inr;
      int i;
      inr    = m_inr(a);
      pend_v = 0;
      if (c && inr) begin
         i = m_idx(a);
         if (w) begin
            pend_v = 1; pend_i = i; pend_old = mem_m[i]; pend_known = known_m[i];
            mem_m[i] = d; known_m[i] = 1;
            mo_wr = mo_wr + 32'd1;
         end else begin
            mo_rd = mo_rd + 32'd1;
         end
      end
      if (c && !inr && !mo_err) begin
         mo_err  = 1;
         mo_erra = a;
      end
`ifdef DATA_RAM_HALT_DETECT_EN
      if (c && w && (a == M_HALT)) mo_halt = 1;
`endif
   endfunction

   function automatic void m_reset();
      if (pend_v) begin
         mem_m[pend_i]   = pend_old;
         known_m[pend_i] = pend_known;
      end
      pend_v = 0; mo_rd = '0; mo_wr = '0; mo_err = 0; mo_erra = '0; mo_halt = 0;
   endfunction

   task automatic m_check(input logic [31:0] a, input logic c);
      if (c && m_inr(a)) begin
         if (known_m[m_idx(a)]) chk("m_rdata", bus_m.ram_data_out, mem_m[m_idx(a)]);
      end else begin
         chk("m_rdata_zero", bus_m.ram_data_out, 32'h0);
      end
      chk("m_err", 32'(m_err), 32'(mo_err));
      chk("m_err_addr", m_err_addr, mo_erra);
      chk("m_rd_cnt", m_rd_cnt, mo_rd);
      chk("m_wr_cnt", m_wr_cnt, mo_wr);
      chk("m_halt", 32'(m_halt), 32'(mo_halt));
   endtask

   // One bus cycle on the main instance: drive, check mid-cycle, clock, update model.
   task automatic mcyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic c,
                       input bit has_exp, input logic [31:0] exp);
      bus_m.ram_addr_in = a; bus_m.ram_data_in = d;
      bus_m.ram_write_request_in = w; bus_m.ram_ce_in = c;
      #3;
      m_check(a, c);
      if (has_exp) chk("m_vec_rdata", bus_m.ram_data_out, exp);
      @(posedge clk_in);
      m_update(a, d, w, c);
      #1;
   endtask

   // One bus cycle on the small instance; the main instance idles meanwhile.
   task automatic scyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic c,
                       input bit has_exp, input logic [31:0] exp);
      bus_m.ram_ce_in = 1'b0; bus_m.ram_write_request_in = 1'b0;
      bus_s.ram_addr_in = a; bus_s.ram_data_in = d;
      bus_s.ram_write_request_in = w; bus_s.ram_ce_in = c;
      #3;
      if (has_exp) chk("s_rdata", bus_s.ram_data_out, exp);
      @(posedge clk_in);
      m_update(32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      bus_s.ram_ce_in = 1'b0;
   endtask

   task automatic do_reset();
      bus_m.ram_addr_in = 32'h10; bus_m.ram_write_request_in = 1'b0; bus_m.ram_ce_in = 1'b1;
      bus_s.ram_addr_in = 32'h0;  bus_s.ram_write_request_in = 1'b0; bus_s.ram_ce_in = 1'b1;
      reset_in = 1'b1;
      m_reset();
      #1;
      chk("rst_m_rdata", bus_m.ram_data_out, 32'h0);
      chk("rst_s_rdata", bus_s.ram_data_out, 32'h0);
      chk("rst_m_err", 32'(m_err), 32'h0);
      chk("rst_m_err_addr", m_err_addr, 32'h0);
      chk("rst_m_cnt", m_rd_cnt | m_wr_cnt, 32'h0);
      chk("rst_s_cnt", s_rd_cnt | s_wr_cnt, 32'h0);
      chk("rst_s_err", 32'(s_err) | s_err_addr, 32'h0);
      chk("rst_halt", 32'(m_halt) | 32'(s_halt), 32'h0);
      @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      bus_m.ram_ce_in = 1'b0;
      bus_s.ram_ce_in = 1'b0;
   endtask

   initial begin
      logic [31:0] a, d;
      logic        w, c;
      logic        exp_halt;

      tbl[0]  = '{32'h20, 32'h1234_5678, 1'b1, 1'b1, 32'h0};
      tbl[1]  = '{32'h20, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
      tbl[2]  = '{32'h20, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[3]  = '{32'h20, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
      tbl[4]  = '{32'h40, 32'hAABB_CCDD, 1'b1, 1'b1, 32'h0};
      tbl[5]  = '{32'h40, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[6]  = '{32'h40, 32'h11BB_CCDD, 1'b1, 1'b1, 32'hAABB_CCDD};
      tbl[7]  = '{32'h40, 32'h0,         1'b0, 1'b1, 32'h11BB_CCDD};
      tbl[8]  = '{32'h50, 32'h1,         1'b1, 1'b1, 32'h0};
      tbl[9]  = '{32'h50, 32'h2,         1'b1, 1'b1, 32'h1};
      tbl[10] = '{32'h50, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[11] = '{32'h50, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[12] = '{32'h50, 32'h0,         1'b0, 1'b1, 32'h2};
      tbl[13] = '{32'h43, 32'h0,         1'b0, 1'b1, 32'h11BB_CCDD};
      tbl[14] = '{32'h100, 32'h0,        1'b0, 1'b1, 32'h0};
      tbl[15] = '{32'h20, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
      tbl[16] = '{32'h20, 32'h0,         1'b0, 1'b1, 32'h1234_5678};

      for (int i = 0; i < M_DEPTH; i++) known_m[i] = 0;
      bus_m.ram_addr_in = '0; bus_m.ram_data_in = '0;
      bus_m.ram_write_request_in = 1'b0; bus_m.ram_ce_in = 1'b0;
      bus_s.ram_addr_in = '0; bus_s.ram_data_in = '0;
      bus_s.ram_write_request_in = 1'b0; bus_s.ram_ce_in = 1'b0;
      #2;
      do_reset();

      // Preload the main array with zeros, let the last write drain, then clear counters.
      for (int i = 0; i < M_DEPTH; i++) mcyc(32'(i * 4), 32'h0, 1'b1, 1'b1, 0, 32'h0);
      mcyc(32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0);
      do_reset();

      for (int i = 0; i < 17; i++) begin
         mcyc(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].c, 1, tbl[i].exp);
         if (i == 3) begin
            chk("wr_then_rd_wr_cnt", m_wr_cnt, 32'd1);
            chk("wr_then_rd_rd_cnt", m_rd_cnt, 32'd2);
         end
      end
      chk("tbl_err_addr", m_err_addr, 32'h100);

      // Reset lands between acceptance and commit of a write: the write must vanish.
      mcyc(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1, 1, 32'h0);
      do_reset();
      chk("rst_mid_wr_cnt", m_wr_cnt, 32'h0);
      mcyc(32'h10, 32'h0, 1'b0, 1'b1, 1, 32'h0);
      mcyc(32'h10, 32'h0, 1'b0, 1'b1, 1, 32'h0);

      // Small instance (16 words): boundary word, ce=0 write, out-of-range capture.
      scyc(32'h00, 32'h77,   1'b1, 1'b1, 0, 32'h0);
      scyc(32'h3C, 32'h3C3C, 1'b1, 1'b1, 0, 32'h0);
      scyc(32'h00, 32'h99,   1'b1, 1'b0, 1, 32'h0);
      scyc(32'h00, 32'h0,    1'b0, 1'b1, 1, 32'h77);
      scyc(32'h3C, 32'h0,    1'b0, 1'b1, 1, 32'h3C3C);
      chk("s_wr_cnt", s_wr_cnt, 32'd2);
      chk("s_rd_cnt", s_rd_cnt, 32'd2);
      chk("s_err_clear", 32'(s_err), 32'h0);
      scyc(32'h40, 32'h0,    1'b0, 1'b1, 1, 32'h0);
      scyc(32'h80, 32'hABCD, 1'b1, 1'b1, 1, 32'h0);
      scyc(32'h00, 32'h0,    1'b0, 1'b0, 1, 32'h0);
      chk("s_err_set", 32'(s_err), 32'h1);
      chk("s_err_addr_first", s_err_addr, 32'h40);
      chk("s_wr_cnt_oor", s_wr_cnt, 32'd2);
      chk("s_rd_cnt_oor", s_rd_cnt, 32'd2);

      // Random traffic concentrated on a few words so forwarding and back-to-back hits are common.
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 79)) << 2;
         else                           a = 32'($urandom_range(0, 9)) << 2;
         a = a | 32'($urandom_range(0, 3));
         d = $urandom;
         w = 1'($urandom_range(0, 1));
         c = ($urandom_range(0, 3) != 0);
         mcyc(a, d, w, c, 0, 32'h0);
      end

`ifdef DATA_RAM_HALT_DETECT_EN
      exp_halt = 1'b1;
`else
      exp_halt = 1'b0;
`endif
      chk("halt_before", 32'(m_halt), 32'h0);
      mcyc(M_HALT, 32'h5, 1'b1, 1'b1, 0, 32'h0);
      chk("halt_after", 32'(m_halt), 32'(exp_halt));
      mcyc(32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0);
      chk("halt_sticky", 32'(m_halt), 32'(exp_halt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
